enc42_queue: RTL and testbench

//  Registered priority encoder: encoding counterpart of the 2:4 decoder. Latches request

---
 rtl/enc42_queue.sv | 86 ++++++++
 tb/tb_enc42_queue.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/enc42_queue.sv
// Registered priority encoder with pending-request latch and valid/ready output.
// Define ENC42_RR_EN for round-robin selection instead of fixed highest-index priority.
module enc42_queue #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [N-1:0] req,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_code,
    output logic [N-1:0] out_oh,
    output logic         idle
);

    logic [N-1:0] pend;
    logic [N-1:0] elig;
    logic [N-1:0] sel_oh;
    logic [W-1:0] sel;
    logic         free;
    logic         load;

`ifdef ENC42_RR_EN
    logic [W-1:0] last;
    logic [W-1:0] idx;
    logic         found;
`endif

    always_comb begin
        elig = pend | (en ? req : '0);
        free = !out_valid || out_ready;
        load = en && free && (elig != '0);
        sel  = '0;
`ifdef ENC42_RR_EN
        idx   = '0;
        found = 1'b0;
        // Search ascends from last+1; the index wraps naturally because N == 2**W.
        for (int k = 0; k < N; k++) begin
            idx = last + W'(1) + W'(k);
            if (!found && elig[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
`else
        for (int i = 0; i < N; i++) begin
            if (elig[i]) sel = W'(i);
        end
`endif
        sel_oh = N'(1) << sel;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend      <= '0;
            out_valid <= 1'b0;
            out_code  <= '0;
            out_oh    <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_code  <= sel;
            out_oh    <= sel_oh;
            // A same-cycle request on the granted line is absorbed by this grant.
            pend      <= elig & ~sel_oh;
        end else begin
            pend <= elig;
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
                out_oh    <= '0;
            end
        end
    end

`ifdef ENC42_RR_EN
    // Reset to N-1 so the first search after reset begins at index 0.
    always_ff @(posedge clk) begin
        if (rst)       last <= W'(N - 1);
        else if (load) last <= sel;
    end
`endif

    assign idle = (pend == '0) && !out_valid;

endmodule

// File: tb/tb_enc42_queue.sv
// Scoreboard bench for enc42_queue: directed stimulus pushes expected codes,
// a negedge monitor pops and compares them on every accepted handshake.
module tb_enc42_queue;

    localparam int N = 4;
    localparam int W = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic [N-1:0] req;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_code;
    logic [N-1:0] out_oh;
    logic         idle;

    int n_checks = 0;
    int n_fails  = 0;
    logic mon_en = 1'b0;
    logic [W-1:0] exp_q[$];

    enc42_queue #(.N(N), .W(W)) dut (
        .clk(clk), .rst(rst), .en(en), .req(req),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_code(out_code), .out_oh(out_oh), .idle(idle)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: a handshake completes at the next rising edge when valid && ready.
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (!out_valid) check("oh_zero_when_invalid", {28'b0, out_oh}, 32'h0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_handshake", {30'b0, out_code}, 32'hFFFF_FFFF);
                end else begin
                    logic [W-1:0] e;
                    logic [N-1:0] eoh;
                    e   = exp_q.pop_front();
                    eoh = N'(1) << e;
                    check("sb_code", {30'b0, out_code}, {30'b0, e});
                    check("sb_oh", {28'b0, out_oh}, {28'b0, eoh});
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; en = 1'b1; req = 4'b1111; out_ready = 1'b1;

        // 1: reset holds outputs at zero and drops requests seen during reset
        step();
        mon_en = 1'b1;
        for (int i = 0; i < 2; i++) begin
            check("rst_valid", {31'b0, out_valid}, 32'd0);
            check("rst_code", {30'b0, out_code}, 32'd0);
            check("rst_oh", {28'b0, out_oh}, 32'd0);
            if (i == 0) step();
        end
        rst = 1'b0; req = 4'b0000;
        step();
        check("post_rst_idle", {31'b0, idle}, 32'd1);

        // 2: single request, one-cycle latency
        req = 4'b0100; exp_q.push_back(2'd2);
        step();
        check("t2_valid", {31'b0, out_valid}, 32'd1);
        check("t2_code", {30'b0, out_code}, 32'd2);
        req = 4'b0000;
        step();
        check("t2_idle", {31'b0, idle}, 32'd1);

        // 3: three simultaneous requests drain one per cycle
        rst = 1'b1;
        step();
        rst = 1'b0;
`ifdef ENC42_RR_EN
        exp_q.push_back(2'd0); exp_q.push_back(2'd1); exp_q.push_back(2'd3);
`else
        exp_q.push_back(2'd3); exp_q.push_back(2'd1); exp_q.push_back(2'd0);
`endif
        req = 4'b1011;
        step();
        req = 4'b0000;
        step();
        step();
        check("t3_valid_last", {31'b0, out_valid}, 32'd1);
        step();
        check("t3_drained", {31'b0, out_valid}, 32'd0);
        check("t3_idle", {31'b0, idle}, 32'd1);

        // 4: back-pressure keeps the code stable, then both codes drain in order
        out_ready = 1'b0;
        req = 4'b0010; exp_q.push_back(2'd1); exp_q.push_back(2'd3);
        for (int i = 0; i < 5; i++) begin
            step();
            req = (i == 1) ? 4'b1000 : 4'b0000;
            check("t4_hold_valid", {31'b0, out_valid}, 32'd1);
            check("t4_hold_code", {30'b0, out_code}, 32'd1);
            check("t4_hold_oh", {28'b0, out_oh}, 32'h2);
        end
        req = 4'b0000;
        out_ready = 1'b1;
        step();
        check("t4_second_code", {30'b0, out_code}, 32'd3);
        step();
        check("t4_idle", {31'b0, idle}, 32'd1);

        // 5: en=0 ignores requests
        en = 1'b0; req = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t5_no_valid", {31'b0, out_valid}, 32'd0);
            check("t5_idle", {31'b0, idle}, 32'd1);
        end
        en = 1'b1; req = 4'b0001; exp_q.push_back(2'd0);
        step();
        check("t5_code", {30'b0, out_code}, 32'd0);
        check("t5_valid", {31'b0, out_valid}, 32'd1);
        req = 4'b0000;
        step();

        // 6: reset discards an in-flight code and pending requests
        out_ready = 1'b0;
        req = 4'b0100;
        step();
        check("t6_code", {30'b0, out_code}, 32'd2);
        req = 4'b1010;
        step();
        req = 4'b0000;
        check("t6_busy", {31'b0, idle}, 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t6_rst_valid", {31'b0, out_valid}, 32'd0);
        check("t6_rst_oh", {28'b0, out_oh}, 32'd0);
        check("t6_rst_idle", {31'b0, idle}, 32'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("t6_no_stale", {31'b0, out_valid}, 32'd0);
        end

        check("sb_empty", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
